mvm3_stream_host: RTL and testbench

//  Host-side endpoint for the mvm3 valid/ready streaming protocol, i.e. the opposite end of the MVM core.
//  A local write port loads one job into an on-chip buffer: a row-major N x N matrix followed by an N-vector.
//  On start, the block serialises the job onto an IN_W-bit valid/ready output stream.
//  It collects the N OUT_W-bit results from the core's output stream into a result file and raises done.

---
 rtl/mvm3_stream_host_if.sv | 23 ++
 rtl/mvm3_stream_host.sv | 151 +++++++++++++++
 tb/tb_mvm3_stream_host.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mvm3_stream_host_if.sv
// Valid/ready stream pair between the mvm3 host and the MVM core.
// master = host view (drives input words, accepts results); slave = core view.
interface mvm3_stream_host_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
);
    logic             m_valid;
    logic             m_ready;
    logic [IN_W-1:0]  m_data;
    logic             s_valid;
    logic             s_ready;
    logic [OUT_W-1:0] s_data;

    modport master (
        output m_valid, m_data, s_ready,
        input  m_ready, s_valid, s_data
    );

    modport slave (
        input  m_valid, m_data, s_ready,
        output m_ready, s_valid, s_data
    );
endinterface

// File: rtl/mvm3_stream_host.sv
// Host endpoint for the mvm3 stream: buffers one N x N matrix + N-vector job,
// streams it to the core on start, and collects the N results into a readable file.
module mvm3_stream_host #(
    parameter int N      = 3,
    parameter int IN_W   = 8,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 4,
    parameter int RD_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [IN_W-1:0]   wr_data,
    input  logic              start,
    mvm3_stream_host_if.master bus,
    input  logic [RD_W-1:0]   rd_addr,
    output logic [OUT_W-1:0]  rd_data,
    output logic              busy,
    output logic              done
);
    localparam int JOB  = N * N + N;
    localparam int TX_W = $clog2(JOB + 1);
    localparam int RX_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IN_W-1:0]   r_buf [JOB];
    logic [OUT_W-1:0]  r_res [N];
    logic [TX_W-1:0]   r_tx_cnt;
    logic [RX_W-1:0]   r_rx_cnt;

    logic              w_tx_more;
    logic              w_rx_more;
    logic              w_wr_ok;
    logic              w_load;
    logic              w_launch;
    logic              w_m_valid;
    logic              w_s_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_tx_fire;
    logic              w_rx_fire;
    logic [IN_W-1:0]   w_m_data;
    logic [OUT_W-1:0]  w_rd_data;

    assign w_tx_more = (r_tx_cnt < TX_W'(JOB));
    assign w_rx_more = (r_rx_cnt < RX_W'(N));
    // Widened compare so a job length equal to 2**ADDR_W cannot wrap to 0.
    assign w_wr_ok   = ({1'b0, wr_addr} < (ADDR_W + 1)'(JOB));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_launch  = 1'b0;
        w_m_valid = 1'b0;
        w_s_ready = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_load = wr_en && w_wr_ok;
                if (start) begin
                    w_launch = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                w_busy    = 1'b1;
                w_m_valid = w_tx_more;
                w_s_ready = w_rx_more;
                if (!w_tx_more && !w_rx_more) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_load = wr_en && w_wr_ok;
                if (start) begin
                    w_launch = 1'b1;
                    w_next   = RUN;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_tx_fire = w_m_valid && bus.m_ready;
    assign w_rx_fire = w_s_ready && bus.s_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf    <= '{default: '0};
            r_res    <= '{default: '0};
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_load) begin
                r_buf[wr_addr] <= wr_data;
            end
            if (w_launch) begin
                r_tx_cnt <= '0;
                r_rx_cnt <= '0;
            end else begin
                if (w_tx_fire) begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
                if (w_rx_fire) begin
                    r_res[r_rx_cnt] <= bus.s_data;
                    r_rx_cnt        <= r_rx_cnt + 1'b1;
                end
            end
        end
    end

    // m_data is a pure function of the registered count, so it cannot move during a stall.
    always_comb begin
        w_m_data = '0;
        if (w_tx_more) begin
            w_m_data = r_buf[r_tx_cnt];
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (rd_addr < RD_W'(N)) begin
            w_rd_data = r_res[rd_addr];
        end
    end

    assign bus.m_valid = w_m_valid;
    assign bus.m_data  = w_m_data;
    assign bus.s_ready = w_s_ready;
    assign rd_data     = w_rd_data;
    assign busy        = w_busy;
    assign done        = w_done;
endmodule

// File: tb/tb_mvm3_stream_host.sv
// Bench for mvm3_stream_host: a behavioural MVM core on the stream side and a
// job-level reference model (buffer contents, matrix-vector products) on the host side.
module tb_mvm3_stream_host;
    localparam int N     = 3;
    localparam int IN_W  = 8;
    localparam int OUT_W = 16;
    localparam int JOB   = N * N + N;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [IN_W-1:0]  wr_data;
    logic             start;
    logic [1:0]       rd_addr;
    logic [OUT_W-1:0] rd_data;
    logic             busy;
    logic             done;

    mvm3_stream_host_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    mvm3_stream_host #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .bus     (bus.master),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [IN_W-1:0]  exp_buf [JOB];
    logic [OUT_W-1:0] exp_res [N];
    logic [IN_W-1:0]  job1 [JOB] = '{8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3,
                                     8'd4, 8'd4, 8'd4, 8'd2, 8'd3, 8'd4};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected result file: signed matrix-vector product of the modelled buffer.
    task automatic model_results();
        for (int r = 0; r < N; r++) begin
            int acc = 0;
            for (int c = 0; c < N; c++)
                acc += int'($signed(exp_buf[r*N+c])) * int'($signed(exp_buf[N*N+c]));
            exp_res[r] = acc[OUT_W-1:0];
        end
    endtask

    task automatic write_word(input int a, input logic [IN_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a[3:0];
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
        if (a < JOB) exp_buf[a] = d;
    endtask

    task automatic load_job(input logic [IN_W-1:0] w [JOB]);
        for (int i = 0; i < JOB; i++) write_word(i, w[i]);
    endtask

    task automatic check_results(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            check_val($sformatf("%s:rd%0d", tag, i), rd_data, (i < N) ? exp_res[i] : '0);
        end
    endtask

    // Starts a job from IDLE/DONE and plays the core until done (or abort).
    task automatic run_job(input string tag, input bit rnd, input bit extra,
                           input int inject_at, input int abort_at);
        logic [IN_W-1:0]  got_w [$];
        logic [OUT_W-1:0] pend [$];
        logic [IN_W-1:0]  held;
        bit               stalled = 1'b0;
        bit               fin = 1'b0;
        int               n_res = 0;
        int               cyc = 0;
        model_results();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val({tag, ":busy_run"}, busy, 1);
        check_val({tag, ":done_run"}, done, 0);
        check_val({tag, ":first_valid"}, bus.m_valid, 1);
        while (!fin && cyc < 2000) begin
            bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pend.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
                bus.s_valid = 1'b1;
                bus.s_data  = pend[0];
            end else begin
                bus.s_valid = 1'b0;
                bus.s_data  = OUT_W'($urandom);
            end
            if (cyc == inject_at) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 4'(JOB - 1);
                wr_data = ~exp_buf[JOB-1];
            end
            #1;
            if (stalled) begin
                check_val($sformatf("%s:hold_valid%0d", tag, cyc), bus.m_valid, 1);
                check_val($sformatf("%s:hold_data%0d", tag, cyc), bus.m_data, held);
            end
            stalled = bus.m_valid && !bus.m_ready;
            held    = bus.m_data;
            if (bus.s_valid && n_res >= N)
                check_val($sformatf("%s:extra_sready%0d", tag, cyc), bus.s_ready, 0);
            if (bus.m_valid && bus.m_ready) begin
                if (got_w.size() >= JOB) begin
                    check_val({tag, ":word_overrun"}, 1, 0);
                end else begin
                    check_val($sformatf("%s:word%0d", tag, got_w.size()), bus.m_data,
                              exp_buf[got_w.size()]);
                    got_w.push_back(bus.m_data);
                    if (got_w.size() == JOB) begin
                        for (int r = 0; r < N; r++) begin
                            int acc = 0;
                            for (int c = 0; c < N; c++)
                                acc += int'($signed(got_w[r*N+c])) * int'($signed(got_w[N*N+c]));
                            pend.push_back(acc[OUT_W-1:0]);
                        end
                    end
                end
            end
            if (bus.s_valid && bus.s_ready) begin
                void'(pend.pop_front());
                n_res++;
                if (n_res == N && extra) pend.push_back(16'hBEEF);
            end
            @(posedge clk);
            if (abort_at > 0 && got_w.size() == abort_at) begin
                #2 reset = 1'b1;
                #1;
                check_val({tag, ":abort_mvalid"}, bus.m_valid, 0);
                check_val({tag, ":abort_sready"}, bus.s_ready, 0);
                check_val({tag, ":abort_busy"}, busy, 0);
                check_val({tag, ":abort_done"}, done, 0);
                exp_buf = '{default: '0};
                exp_res = '{default: '0};
                check_results({tag, ":abort"});
                @(negedge clk);
                reset       = 1'b0;
                start       = 1'b0;
                wr_en       = 1'b0;
                bus.s_valid = 1'b0;
                return;
            end
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            cyc++;
            fin = done;
        end
        if (!fin) check_val({tag, ":timeout"}, 0, 1);
        check_val({tag, ":words_sent"}, got_w.size(), JOB);
        check_val({tag, ":done"}, done, 1);
        check_val({tag, ":busy_done"}, busy, 0);
        check_val({tag, ":mvalid_done"}, bus.m_valid, 0);
        #1;
        check_val({tag, ":sready_done"}, bus.s_ready, 0);
        bus.s_valid = 1'b0;
        check_results(tag);
    endtask

    initial begin
        logic [IN_W-1:0]  rjob [JOB];
        logic [OUT_W-1:0] k1 [N] = '{16'd18, 16'd27, 16'd36};
        logic [OUT_W-1:0] k6 [N] = '{16'd2, 16'd3, 16'd4};
        reset       = 1'b1;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        start       = 1'b0;
        rd_addr     = '0;
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        exp_buf     = '{default: '0};
        exp_res     = '{default: '0};
        repeat (2) @(negedge clk);
        check_val("rst:mvalid", bus.m_valid, 0);
        check_val("rst:sready", bus.s_ready, 0);
        check_val("rst:busy", busy, 0);
        check_val("rst:done", done, 0);
        check_results("rst");
        reset = 1'b0;
        @(negedge clk);

        load_job(job1);
        run_job("t1", 1'b0, 1'b0, -1, 0);
        for (int i = 0; i < N; i++) begin
            rd_addr = 2'(i);
            #1 check_val($sformatf("t1:const%0d", i), rd_data, k1[i]);
        end
        @(negedge clk);

        run_job("t2", 1'b1, 1'b0, -1, 0);
        @(negedge clk);
        run_job("t3", 1'b1, 1'b1, -1, 0);
        @(negedge clk);
        run_job("t5", 1'b0, 1'b0, 3, 0);
        @(negedge clk);
        run_job("t5b", 1'b1, 1'b0, -1, 0);
        @(negedge clk);

        run_job("t4", 1'b0, 1'b0, -1, 5);
        run_job("t4z", 1'b1, 1'b0, -1, 0);
        @(negedge clk);
        load_job(job1);
        run_job("t4r", 1'b0, 1'b0, -1, 0);
        @(negedge clk);

        write_word(9, 8'd1);
        write_word(10, 8'd0);
        write_word(11, 8'd0);
        run_job("t6", 1'b1, 1'b0, -1, 0);
        for (int i = 0; i < N; i++) begin
            rd_addr = 2'(i);
            #1 check_val($sformatf("t6:const%0d", i), rd_data, k6[i]);
        end
        @(negedge clk);

        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < JOB; i++) rjob[i] = IN_W'($urandom);
            load_job(rjob);
            write_word(12 + int'($urandom_range(0, 3)), IN_W'($urandom));
            run_job($sformatf("rnd%0d", j), 1'b1, j[0], -1, 0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
